// File: rtl/mono_fb_writer_pkg.sv
// Shared video constants for the mono framebuffer path: default geometry and address width.
// Words are 16 horizontal pixels, so one framebuffer line holds FB_WIDTH/16 words.
package mono_fb_writer_pkg;

    localparam int FB_WIDTH_DEF       = 640;
    localparam int FB_HEIGHT_DEF      = 480;
    localparam int PIX_PER_WORD       = 16;
    localparam int WORDS_PER_LINE_DEF = FB_WIDTH_DEF / PIX_PER_WORD;
    localparam int ADDR_BITS_DEF      = 15;
    localparam int COORD_BITS         = 12;
    localparam int WORD_BITS          = 16;

endpackage

// File: rtl/mono_word_fifo.sv
// First-word-fall-through word FIFO; head visible the cycle after the push, no extra read latency.
// A push while full is refused unless a pop happens in the same cycle, which frees the slot.
module mono_word_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mono_fb_writer.sv
// Clips dithered 16-pixel words to the framebuffer window and queues address/data writes.
// bits_ready to fb_wen is 3 cycles; fb_wready stalls the FIFO head, a push into a full FIFO drops the word.
module mono_fb_writer
    import mono_fb_writer_pkg::*;
#(
    parameter int FB_WIDTH   = FB_WIDTH_DEF,
    parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bits_ready,
    input  logic [WORD_BITS-1:0]  bits,
    input  logic [COORD_BITS-1:0] xaddr,
    input  logic [COORD_BITS-1:0] yaddr,
    input  logic                  vsync,
    input  logic [COORD_BITS-1:0] x_offset,
    input  logic [COORD_BITS-1:0] y_offset,
    output logic [ADDR_BITS-1:0]  fb_waddr,
    output logic [WORD_BITS-1:0]  fb_wdata,
    output logic                  fb_wen,
    input  logic                  fb_wready,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [WORD_BITS-1:0] dat;
    } fb_word_t;

    localparam logic [ADDR_BITS-1:0] WPL = ADDR_BITS'(FB_WIDTH / PIX_PER_WORD);

    logic [COORD_BITS-1:0] xo, yo;
    logic [COORD_BITS-1:0] dx, dy;
    logic                  x_in, y_in;

    logic                  s1_vld, s1_win;
    logic [7:0]            s1_col;
    logic [COORD_BITS-1:0] s1_dy;
    logic [WORD_BITS-1:0]  s1_dat;

    logic                  s2_vld;
    logic [ADDR_BITS-1:0]  s2_addr;
    logic [WORD_BITS-1:0]  s2_dat;
    logic [ADDR_BITS-1:0]  line_base;

    fb_word_t              fifo_din, fifo_head;
    logic                  fifo_full, fifo_empty, pop, drop;

    // Comparisons use the registered offsets, so a word arriving with vsync sees the old window.
    assign dx   = xaddr - xo;
    assign dy   = yaddr - yo;
    assign x_in = (xaddr >= xo) && (int'(dx) < FB_WIDTH);
    assign y_in = (yaddr >= yo) && (int'(dy) < FB_HEIGHT);

    // Constant-coefficient product only; WPL is an elaboration-time constant.
    assign line_base = ADDR_BITS'(s1_dy) * WPL;

    assign pop  = fb_wen && fb_wready;
    assign drop = s2_vld && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xo          <= '0;
            yo          <= '0;
            frame_count <= '0;
            s1_vld      <= 1'b0;
            s1_win      <= 1'b0;
            s1_col      <= '0;
            s1_dy       <= '0;
            s1_dat      <= '0;
            s2_vld      <= 1'b0;
            s2_addr     <= '0;
            s2_dat      <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (vsync) begin
                xo          <= x_offset & 12'hFF0;
                yo          <= y_offset;
                frame_count <= frame_count + 1'b1;
            end
            s1_vld  <= bits_ready;
            s1_win  <= x_in && y_in;
            s1_col  <= dx[11:4];
            s1_dy   <= dy;
            s1_dat  <= bits;
            s2_vld  <= s1_vld && s1_win;
            s2_addr <= line_base + ADDR_BITS'(s1_col);
            s2_dat  <= s1_dat;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign fifo_din.addr = s2_addr;
    assign fifo_din.dat  = s2_dat;

    mono_word_fifo #(
        .WIDTH ($bits(fb_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_vld),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gating on fb_wen keeps address/data at zero whenever the queue is empty, including reset.
    assign fb_wen   = !fifo_empty;
    assign fb_waddr = fb_wen ? fifo_head.addr : '0;
    assign fb_wdata = fb_wen ? fifo_head.dat  : '0;

endmodule
